pio_write_master: RTL

PIO_WRITE_MASTER -- requirements
Module: pio_write_master

---
 rtl/pio_write_master.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pio_write_master.sv
// Write-and-verify master for a single Avalon-MM PIO slave register.
// Ports: clk, reset (async, active-high); cmd_valid/cmd_data/cmd_ready
//   command handshake; avm_* Avalon-MM master signals; busy, done and
//   error status pulses; rd_value holds the last readback word.
module pio_write_master #(
    parameter int unsigned TARGET_ADDR = 0,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] rd_value
);

    localparam logic [1:0] ADDR = TARGET_ADDR[1:0];
    localparam logic [3:0] MAXR = MAX_RETRY[3:0];
    localparam logic [8:0] TMO  = TIMEOUT[8:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CHECK,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [31:0] data_q;
    logic [31:0] rd_value_q;
    logic [31:0] wdata_q;
    logic [1:0]  addr_q;
    logic        cs_q;
    logic        wr_n_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [3:0]  retry_q;
    logic [7:0]  stall_q;

    logic [8:0]  stall_inc_d;
    logic [7:0]  stall_d;
    logic        timeout_d;
    logic        match_d;

    // Stall count this cycle would reach; the transfer gives up once the
    // count of stalled cycles reaches TIMEOUT with the slave still stalling.
    assign stall_inc_d = {1'b0, stall_q} + 9'd1;
    assign stall_d     = (stall_q == 8'hFF) ? stall_q : stall_inc_d[7:0];
    assign timeout_d   = (stall_inc_d >= TMO);
    assign match_d     = (rd_value_q == data_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            rd_value_q <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            cs_q       <= 1'b0;
            wr_n_q     <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            retry_q    <= '0;
            stall_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        data_q  <= cmd_data;
                        wdata_q <= cmd_data;
                        addr_q  <= ADDR;
                        retry_q <= '0;
                        stall_q <= '0;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_WRITE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (avm_waitrequest) begin
                        if (timeout_d) begin
                            cs_q    <= 1'b0;
                            wr_n_q  <= 1'b1;
                            error_q <= 1'b1;
                            state_q <= S_RESP;
                        end else begin
                            stall_q <= stall_d;
                        end
                    end else begin
                        // Chipselect stays up; the read follows directly.
                        stall_q <= '0;
                        wr_n_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (avm_waitrequest) begin
                        if (timeout_d) begin
                            cs_q    <= 1'b0;
                            error_q <= 1'b1;
                            state_q <= S_RESP;
                        end else begin
                            stall_q <= stall_d;
                        end
                    end else begin
                        rd_value_q <= avm_readdata;
                        stall_q    <= '0;
                        cs_q       <= 1'b0;
                        state_q    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (match_d) begin
                        done_q  <= 1'b1;
                        state_q <= S_RESP;
                    end else if (retry_q < MAXR) begin
                        retry_q <= retry_q + 4'd1;
                        stall_q <= '0;
                        wdata_q <= data_q;
                        addr_q  <= ADDR;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                        state_q <= S_WRITE;
                    end else begin
                        error_q <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    cs_q    <= 1'b0;
                    wr_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = ready_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wr_n_q;
    assign avm_writedata  = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign rd_value       = rd_value_q;

endmodule
